// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-atomic arbiter sharing one GMII TX path between the
// ARP and UDP engines (gmii_tx_clk domain).
//   clk, rst                  : GMII TX clock, synchronous active-high reset
//   arp_req / udp_req         : level requests, held until granted
//   arp_gnt / udp_gnt         : one-hot (or zero) ownership of the TX path
//   arp_gmii_* / udp_gmii_*   : per-source GMII byte streams
//   gmii_tx_en / gmii_txd     : arbitrated stream, one cycle registered latency
//   busy                      : arbiter not idle
//   err_timeout, err_oversize : one-cycle error pulses
module eth_tx_arbiter #(
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned START_TO   = 64,
  parameter int unsigned MAX_FRAME  = 1530
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arp_req,
  input  logic       udp_req,
  output logic       arp_gnt,
  output logic       udp_gnt,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_oversize
);

  localparam int unsigned TO_W   = 10;
  localparam int unsigned BYTE_W = 11;
  localparam int unsigned IFG_W  = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FRAME = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_IFG   = 3'd4;

  logic [2:0]        state, state_d;
  logic              owner_udp, owner_udp_d;
  logic              last_udp, last_udp_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_d;
  logic [IFG_W-1:0]  ifg_cnt, ifg_cnt_d;
  logic              tx_en_d;
  logic [7:0]        txd_d;
  logic              err_to_d, err_ov_d;
  logic              win_udp;
  logic              own_en;
  logic [7:0]        own_txd;

  // Grants follow the registered state/owner; DRAIN and IFG hold no grant.
  assign arp_gnt = ((state == S_WAIT) || (state == S_FRAME)) && !owner_udp;
  assign udp_gnt = ((state == S_WAIT) || (state == S_FRAME)) &&  owner_udp;
  assign busy    = (state != S_IDLE);

  // Only the current owner's stream is ever looked at.
  assign own_en  = owner_udp ? udp_gmii_tx_en : arp_gmii_tx_en;
  assign own_txd = owner_udp ? udp_gmii_txd   : arp_gmii_txd;

  // Tie break: round-robin picks the source opposite the last winner,
  // fixed priority always picks ARP.
  always_comb begin
    win_udp = udp_req;
    if (arp_req && udp_req) begin
      win_udp = (ARB_MODE == 0) ? !last_udp : 1'b0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    owner_udp_d = owner_udp;
    last_udp_d  = last_udp;
    to_cnt_d    = to_cnt;
    byte_cnt_d  = byte_cnt;
    ifg_cnt_d   = ifg_cnt;
    tx_en_d     = 1'b0;
    txd_d       = '0;
    err_to_d    = 1'b0;
    err_ov_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (arp_req || udp_req) begin
          owner_udp_d = win_udp;
          last_udp_d  = win_udp;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (own_en) begin
          tx_en_d = 1'b1;
          txd_d   = own_txd;
          state_d = S_FRAME;
        end else if (to_cnt == TO_W'(START_TO - 1)) begin
          // Counter would reach START_TO on this edge.
          err_to_d = 1'b1;
          state_d  = S_IFG;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      S_FRAME: begin
        if (!own_en) begin
          state_d = S_IFG;
        end else if (byte_cnt == BYTE_W'(MAX_FRAME)) begin
          err_ov_d = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          tx_en_d    = 1'b1;
          txd_d      = own_txd;
          byte_cnt_d = byte_cnt + BYTE_W'(1);
        end
      end
      S_DRAIN: begin
        if (!own_en) state_d = S_IFG;
      end
      S_IFG: begin
        if (ifg_cnt == IFG_W'(IFG_CYCLES)) state_d = S_IDLE;
        else ifg_cnt_d = ifg_cnt + IFG_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Counters restart on every state change; the byte counter starts at 1
    // because the first byte is forwarded on the edge that enters FRAME.
    if (state_d != state) begin
      to_cnt_d   = '0;
      ifg_cnt_d  = '0;
      byte_cnt_d = (state_d == S_FRAME) ? BYTE_W'(1) : '0;
    end
  end

  // State, owner, counters and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      owner_udp    <= 1'b0;
      last_udp     <= 1'b1;
      to_cnt       <= '0;
      byte_cnt     <= '0;
      ifg_cnt      <= '0;
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= '0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_d;
      owner_udp    <= owner_udp_d;
      last_udp     <= last_udp_d;
      to_cnt       <= to_cnt_d;
      byte_cnt     <= byte_cnt_d;
      ifg_cnt      <= ifg_cnt_d;
      gmii_tx_en   <= tx_en_d;
      gmii_txd     <= txd_d;
      err_timeout  <= err_to_d;
      err_oversize <= err_ov_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: round-robin instance (MAX_FRAME=100) with
// behavioural byte sources and a byte scoreboard, plus a fixed-priority
// instance with simple 8-byte sources.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

  localparam int MAXF = 100;

  logic clk;
  logic rst = 1'b1;

  // Round-robin instance signals
  logic       arp_req = 1'b0, udp_req = 1'b0;
  logic       arp_gnt, udp_gnt;
  logic       arp_gmii_tx_en = 1'b0, udp_gmii_tx_en = 1'b0;
  logic [7:0] arp_gmii_txd = '0, udp_gmii_txd = '0;
  logic       gmii_tx_en, busy, err_timeout, err_oversize;
  logic [7:0] gmii_txd;

  // Fixed-priority instance signals
  logic       p_arp_req = 1'b0, p_udp_req = 1'b0;
  logic       p_arp_gnt, p_udp_gnt;
  logic       p_arp_gmii_tx_en = 1'b0, p_udp_gmii_tx_en = 1'b0;
  logic [7:0] p_arp_gmii_txd = '0, p_udp_gmii_txd = '0;
  logic       p_gmii_tx_en, p_busy, p_err_timeout, p_err_oversize;
  logic [7:0] p_gmii_txd;

  int n_tests = 0, n_fail = 0;

  logic [7:0] exp_q[$];
  int grant_log[$];
  int a_len = 0, u_len = 0, a_sent = 0, u_sent = 0, a_seed = 0, u_seed = 0;
  bit a_act = 0, u_act = 0, u_mute = 0;
  int fwd_cnt = 0, ov_cnt = 0, gap = 0;
  bit seen_fall = 0;
  logic arp_gnt_q = 0, udp_gnt_q = 0, tx_en_q = 0, p_arp_q = 0, p_udp_q = 0;
  int p_arp_grants = 0, p_udp_grants = 0, p_a_cnt = 0, p_u_cnt = 0;

  typedef struct {
    logic arp;
    logic udp;
    logic exp_arp;
    logic exp_udp;
    int   len;
  } vec_t;
  vec_t tbl[10];

  eth_tx_arbiter #(.ARB_MODE(0), .IFG_CYCLES(12), .START_TO(64), .MAX_FRAME(MAXF)) dut (
    .clk(clk), .rst(rst), .arp_req(arp_req), .udp_req(udp_req),
    .arp_gnt(arp_gnt), .udp_gnt(udp_gnt),
    .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
    .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .busy(busy),
    .err_timeout(err_timeout), .err_oversize(err_oversize));

  eth_tx_arbiter #(.ARB_MODE(1), .IFG_CYCLES(12), .START_TO(64), .MAX_FRAME(MAXF)) dut_fp (
    .clk(clk), .rst(rst), .arp_req(p_arp_req), .udp_req(p_udp_req),
    .arp_gnt(p_arp_gnt), .udp_gnt(p_udp_gnt),
    .arp_gmii_tx_en(p_arp_gmii_tx_en), .arp_gmii_txd(p_arp_gmii_txd),
    .udp_gmii_tx_en(p_udp_gmii_tx_en), .udp_gmii_txd(p_udp_gmii_txd),
    .gmii_tx_en(p_gmii_tx_en), .gmii_txd(p_gmii_txd), .busy(p_busy),
    .err_timeout(p_err_timeout), .err_oversize(p_err_oversize));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  // Round-robin instance sources: start one cycle after seeing the grant,
  // push every byte that should survive truncation onto the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (a_act) begin
        if (a_sent < a_len) begin
          arp_gmii_tx_en = 1'b1;
          arp_gmii_txd   = 8'(a_sent * 7 + a_seed);
          if (a_sent < MAXF) exp_q.push_back(arp_gmii_txd);
          a_sent++;
        end else begin
          arp_gmii_tx_en = 1'b0;
          arp_gmii_txd   = 8'($urandom);
          a_act          = 0;
        end
      end else begin
        arp_gmii_txd = 8'($urandom);
        if (arp_gnt && !rst) begin
          a_act  = 1;
          a_sent = 0;
          a_seed = a_seed + 3;
        end
      end
      if (u_act) begin
        if (u_sent < u_len) begin
          udp_gmii_tx_en = 1'b1;
          udp_gmii_txd   = 8'(u_sent * 5 + u_seed + 128);
          if (u_sent < MAXF) exp_q.push_back(udp_gmii_txd);
          u_sent++;
        end else begin
          udp_gmii_tx_en = 1'b0;
          udp_gmii_txd   = 8'($urandom);
          u_act          = 0;
        end
      end else begin
        udp_gmii_txd = 8'($urandom);
        if (udp_gnt && !rst && !u_mute) begin
          u_act  = 1;
          u_sent = 0;
          u_seed = u_seed + 11;
        end
      end
    end
  end

  // Fixed-priority instance sources: 8-byte frames while granted.
  initial begin
    forever begin
      @(negedge clk);
      if (p_arp_gnt && p_a_cnt < 8) begin
        p_arp_gmii_tx_en = 1'b1;
        p_arp_gmii_txd   = 8'(p_a_cnt);
        p_a_cnt++;
      end else begin
        p_arp_gmii_tx_en = 1'b0;
        if (!p_arp_gnt) p_a_cnt = 0;
      end
      if (p_udp_gnt && p_u_cnt < 8) begin
        p_udp_gmii_tx_en = 1'b1;
        p_udp_gmii_txd   = 8'(p_u_cnt + 64);
        p_u_cnt++;
      end else begin
        p_udp_gmii_tx_en = 1'b0;
        if (!p_udp_gnt) p_u_cnt = 0;
      end
    end
  end

  // Output monitor: scoreboard pop, gap, one-hot and idle-zero checks.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("gnt_onehot", 32'(arp_gnt & udp_gnt), 0);
        chk("p_gnt_onehot", 32'(p_arp_gnt & p_udp_gnt), 0);
        chk("p_no_err", 32'(p_err_timeout | p_err_oversize), 0);
        if (arp_gnt && !arp_gnt_q) grant_log.push_back(0);
        if (udp_gnt && !udp_gnt_q) grant_log.push_back(1);
        if (p_arp_gnt && !p_arp_q) p_arp_grants++;
        if (p_udp_gnt && !p_udp_q) p_udp_grants++;
        if (err_oversize) ov_cnt++;
        if (!p_gmii_tx_en) chk("p_txd_idle_zero", 32'(p_gmii_txd), 0);
        if (gmii_tx_en) begin
          chk("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("byte", 32'(gmii_txd), 32'(e));
          end
          if (!tx_en_q && seen_fall) begin
            chk("ifg_gap_ge_14", 32'(gap >= 14), 1);
            seen_fall = 0;
          end
          gap = 0;
          fwd_cnt++;
        end else begin
          if (tx_en_q) seen_fall = 1;
          gap++;
          chk("txd_idle_zero", 32'(gmii_txd), 0);
        end
      end
      arp_gnt_q = arp_gnt;
      udp_gnt_q = udp_gnt;
      tx_en_q   = gmii_tx_en;
      p_arp_q   = p_arp_gnt;
      p_udp_q   = p_udp_gnt;
    end
  end

  initial begin
    int n;
    // {arp_req, udp_req, exp_arp_gnt, exp_udp_gnt, frame length}
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 7};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 5};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 6};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 9};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 2};

    repeat (3) step();
    chk("rst_arp_gnt", 32'(arp_gnt), 0);
    chk("rst_udp_gnt", 32'(udp_gnt), 0);
    chk("rst_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_txd", 32'(gmii_txd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", 32'({err_timeout, err_oversize}), 0);
    chk("rst_p_busy", 32'(p_busy), 0);
    rst = 1'b0;
    step();

    // Arbitration decisions, starting from the reset pointer.
    for (int i = 0; i < 10; i++) begin
      a_len   = tbl[i].len;
      u_len   = tbl[i].len;
      arp_req = tbl[i].arp;
      udp_req = tbl[i].udp;
      step();
      chk($sformatf("vec%0d_arp_gnt", i), 32'(arp_gnt), 32'(tbl[i].exp_arp));
      chk($sformatf("vec%0d_udp_gnt", i), 32'(udp_gnt), 32'(tbl[i].exp_udp));
      arp_req = 1'b0;
      udp_req = 1'b0;
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_sb_empty", i), 32'(exp_q.size()), 0);
    end

    // Round-robin tie with both requests held: ARP, UDP, ARP, UDP.
    grant_log.delete();
    a_len = 64; u_len = 64;
    arp_req = 1'b1; udp_req = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 2000) begin
      step();
      n++;
    end
    arp_req = 1'b0; udp_req = 1'b0;
    chk("rr_grant_count", 32'(grant_log.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk($sformatf("rr_order%0d", i), 32'(grant_log[i]), 32'(i % 2));
    wait_idle("rr");
    chk("rr_sb_empty", 32'(exp_q.size()), 0);

    // Single ARP frame: latency, grant release, IFG length.
    fwd_cnt = 0; a_len = 60;
    arp_req = 1'b1;
    step();
    chk("single_arp_gnt", 32'(arp_gnt), 1);
    arp_req = 1'b0;
    n = 0;
    while (!arp_gmii_tx_en && n < 10) begin step(); n++; end
    chk("single_first_en", 32'(gmii_tx_en), 1);
    chk("single_first_txd", 32'(gmii_txd), 32'(arp_gmii_txd));
    n = 0;
    while (arp_gmii_tx_en && n < 100) begin step(); n++; end
    chk("single_gnt_drop", 32'(arp_gnt), 0);
    chk("single_busy_ifg", 32'(busy), 1);
    chk("single_tail_en", 32'(gmii_tx_en), 0);
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("single_ifg_cycles", 32'(n), 13);
    chk("single_fwd_cnt", 32'(fwd_cnt), 60);

    // Start timeout: UDP never drives tx_en.
    u_mute = 1; fwd_cnt = 0;
    udp_req = 1'b1;
    step();
    chk("to_udp_gnt", 32'(udp_gnt), 1);
    udp_req = 1'b0;
    n = 0;
    while (!err_timeout && n < 200) begin step(); n++; end
    chk("to_latency", 32'(n), 64);
    chk("to_gnt_drop", 32'(udp_gnt), 0);
    chk("to_busy", 32'(busy), 1);
    step();
    chk("to_pulse_one_cycle", 32'(err_timeout), 0);
    wait_idle("to");
    chk("to_no_output", 32'(fwd_cnt), 0);
    u_mute = 0;

    // Oversize: 150-byte UDP frame truncated at 100.
    fwd_cnt = 0; ov_cnt = 0; u_len = 150;
    udp_req = 1'b1;
    step();
    udp_req = 1'b0;
    n = 0;
    while (!err_oversize && n < 300) begin step(); n++; end
    chk("ov_pulse_seen", 32'(err_oversize), 1);
    chk("ov_gnt_drop", 32'(udp_gnt), 0);
    chk("ov_busy_drain", 32'(busy), 1);
    n = 0;
    while (udp_gmii_tx_en && n < 100) begin step(); n++; end
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("ov_ifg_cycles", 32'(n), 13);
    chk("ov_fwd_cnt", 32'(fwd_cnt), MAXF);
    chk("ov_pulse_count", 32'(ov_cnt), 1);
    chk("ov_sb_empty", 32'(exp_q.size()), 0);

    // Fixed priority: UDP starves while ARP keeps requesting.
    p_arp_grants = 0; p_udp_grants = 0;
    p_arp_req = 1'b1; p_udp_req = 1'b1;
    n = 0;
    while (p_arp_grants < 3 && n < 500) begin step(); n++; end
    p_arp_req = 1'b0;
    chk("fp_arp_grants", 32'(p_arp_grants), 3);
    chk("fp_udp_starved", 32'(p_udp_grants), 0);
    n = 0;
    while (p_udp_grants < 1 && n < 200) begin step(); n++; end
    p_udp_req = 1'b0;
    chk("fp_udp_after_arp", 32'(p_udp_grants), 1);
    chk("fp_arp_no_extra", 32'(p_arp_grants), 3);
    n = 0;
    while (p_busy && n < 200) begin step(); n++; end
    chk("fp_idle", 32'(p_busy), 0);

    // Reset in the middle of a UDP frame.
    fwd_cnt = 0; u_len = 40;
    udp_req = 1'b1;
    step();
    udp_req = 1'b0;
    n = 0;
    while (fwd_cnt < 30 && n < 100) begin step(); n++; end
    rst = 1'b1;
    step();
    chk("mid_rst_tx_en", 32'(gmii_tx_en), 0);
    chk("mid_rst_grants", 32'({arp_gnt, udp_gnt}), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    u_len = 0;
    step();
    exp_q.delete();
    fwd_cnt = 0; a_len = 10;
    rst = 1'b0;
    arp_req = 1'b1;
    step();
    chk("post_rst_arp_gnt", 32'(arp_gnt), 1);
    arp_req = 1'b0;
    wait_idle("post_rst");
    chk("post_rst_fwd_cnt", 32'(fwd_cnt), 10);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
